// File: rtl/muldiv_unit.sv
// Execute-stage multiply/divide unit that owns HI/LO and reports busy to the hazard monitor.
// Optional accumulate ops (madd/msub, mdctr 4/5) are built only when MULDIV_MADD_EN is defined.
module muldiv_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  mdctr,
    input  logic        hiwrite,
    input  logic        lowrite,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        phi_q, phi_d;
    logic [31:0]        plo_q, plo_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic               op_valid;
    logic [CNT_W-1:0]   op_cycles;
    logic [63:0]        op_result;
    logic [63:0]        prod_s, prod_u;
    logic [31:0]        a_mag, b_mag, dvd, dvs, quot, rem, quot_s, rem_s;
    logic               signed_div;

    // Result datapath: evaluated from the operands present at the start edge.
    always_comb begin
        prod_s     = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u     = {32'b0, a} * {32'b0, b};
        a_mag      = a[31] ? -a : a;
        b_mag      = b[31] ? -b : b;
        signed_div = (mdctr == 3'd2);
        dvd        = signed_div ? a_mag : a;
        dvs        = signed_div ? b_mag : b;
        quot       = '0;
        rem        = '0;
        if (dvs != '0) begin
            quot = dvd / dvs;
            rem  = dvd % dvs;
        end
        // Magnitude division then sign fix-up also covers 0x80000000 / -1 without overflow.
        quot_s     = (a[31] ^ b[31]) ? -quot : quot;
        rem_s      = a[31] ? -rem : rem;

        op_valid   = 1'b1;
        op_cycles  = CNT_W'(MULT_CYCLES);
        op_result  = {hi_q, lo_q};
        case (mdctr)
            3'd0: op_result = prod_s;
            3'd1: op_result = prod_u;
            3'd2: begin
                op_cycles = CNT_W'(DIV_CYCLES);
                if (b != '0) op_result = {rem_s, quot_s};
            end
            3'd3: begin
                op_cycles = CNT_W'(DIV_CYCLES);
                if (b != '0) op_result = {rem, quot};
            end
`ifdef MULDIV_MADD_EN
            3'd4: op_result = {hi_q, lo_q} + prod_s;
            3'd5: op_result = {hi_q, lo_q} - prod_s;
`endif
            default: op_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op_valid) begin
                        state_d        = RUN;
                        cnt_d          = op_cycles;
                        {phi_d, plo_d} = op_result;
                    end
                end else begin
                    if (hiwrite) hi_d = a;
                    if (lowrite) lo_d = a;
                end
            end
            RUN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
